// File: rtl/wb_ibus_dbus_arbiter.sv
// Two-master (ibus m0, dbus m1) to one-slave Wishbone arbiter with registered round-robin grant.
// Grant is held for a whole CYC; a per-transfer watchdog aborts stalled slave accesses with ERR.
module wb_ibus_dbus_arbiter #(
  parameter int AW      = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [AW-1:0] i_m0_adr,
  input  logic [31:0]   i_m0_dat,
  input  logic [3:0]    i_m0_sel,
  input  logic          i_m0_we,
  input  logic          i_m0_cyc,
  input  logic          i_m0_stb,
  input  logic [2:0]    i_m0_cti,
  input  logic [1:0]    i_m0_bte,
  output logic [31:0]   o_m0_rdt,
  output logic          o_m0_ack,
  output logic          o_m0_err,
  input  logic [AW-1:0] i_m1_adr,
  input  logic [31:0]   i_m1_dat,
  input  logic [3:0]    i_m1_sel,
  input  logic          i_m1_we,
  input  logic          i_m1_cyc,
  input  logic          i_m1_stb,
  input  logic [2:0]    i_m1_cti,
  input  logic [1:0]    i_m1_bte,
  output logic [31:0]   o_m1_rdt,
  output logic          o_m1_ack,
  output logic          o_m1_err,
  output logic [AW-1:0] o_s_adr,
  output logic [31:0]   o_s_dat,
  output logic [3:0]    o_s_sel,
  output logic          o_s_we,
  output logic          o_s_cyc,
  output logic          o_s_stb,
  output logic [2:0]    o_s_cti,
  output logic [1:0]    o_s_bte,
  input  logic [31:0]   i_s_rdt,
  input  logic          i_s_ack,
  input  logic          i_s_err,
  output logic          o_timeout,
  output logic [1:0]    o_grant
);

  typedef enum logic [1:0] {IDLE, G0, G1, ABORT} state_t;

  localparam bit          WD_EN    = (TIMEOUT > 0);
  localparam logic [15:0] CNT_LAST = WD_EN ? 16'(TIMEOUT - 1) : 16'd0;

  state_t      state, state_nx;
  logic        last, last_nx;
  logic [15:0] cnt, cnt_nx;
  logic        granted, stall, fire;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      last  <= 1'b1;
      cnt   <= 16'd0;
    end else begin
      state <= state_nx;
      last  <= last_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    o_s_adr   = '0;
    o_s_dat   = '0;
    o_s_sel   = '0;
    o_s_we    = 1'b0;
    o_s_cyc   = 1'b0;
    o_s_stb   = 1'b0;
    o_s_cti   = '0;
    o_s_bte   = '0;
    o_m0_rdt  = '0;
    o_m1_rdt  = '0;
    o_m0_ack  = 1'b0;
    o_m1_ack  = 1'b0;
    o_m0_err  = 1'b0;
    o_m1_err  = 1'b0;
    o_timeout = 1'b0;
    o_grant   = {state == G1, state == G0};
    granted   = (state == G0) || (state == G1);
    state_nx  = state;

    // Request mux selected purely by registered state: no path from slave inputs.
    if (state == G0) begin
      o_s_adr = i_m0_adr;
      o_s_dat = i_m0_dat;
      o_s_sel = i_m0_sel;
      o_s_we  = i_m0_we;
      o_s_cyc = i_m0_cyc;
      o_s_stb = i_m0_stb;
      o_s_cti = i_m0_cti;
      o_s_bte = i_m0_bte;
    end else if (state == G1) begin
      o_s_adr = i_m1_adr;
      o_s_dat = i_m1_dat;
      o_s_sel = i_m1_sel;
      o_s_we  = i_m1_we;
      o_s_cyc = i_m1_cyc;
      o_s_stb = i_m1_stb;
      o_s_cti = i_m1_cti;
      o_s_bte = i_m1_bte;
    end

    if (granted) begin
      o_m0_rdt = i_s_rdt;
      o_m1_rdt = i_s_rdt;
    end
    o_m0_ack = (state == G0) && i_s_ack;
    o_m1_ack = (state == G1) && i_s_ack;
    o_m0_err = ((state == G0) && i_s_err) || ((state == ABORT) && !last);
    o_m1_err = ((state == G1) && i_s_err) || ((state == ABORT) && last);
    o_timeout = (state == ABORT);

    stall = granted && o_s_cyc && o_s_stb && !i_s_ack && !i_s_err;
    fire  = WD_EN && stall && (cnt == CNT_LAST);

    case (state)
      IDLE: begin
        if (i_m0_cyc && i_m1_cyc) state_nx = last ? G0 : G1;
        else if (i_m0_cyc)        state_nx = G0;
        else if (i_m1_cyc)        state_nx = G1;
      end
      G0: begin
        if (fire)           state_nx = ABORT;
        else if (!i_m0_cyc) state_nx = i_m1_cyc ? G1 : IDLE;
      end
      G1: begin
        if (fire)           state_nx = ABORT;
        else if (!i_m1_cyc) state_nx = i_m0_cyc ? G0 : IDLE;
      end
      default: state_nx = IDLE;
    endcase

    // While in a grant state, `last` already names the granted master, so ABORT reuses it.
    last_nx = (state_nx == G1) ? 1'b1 : (state_nx == G0) ? 1'b0 : last;
    cnt_nx  = (stall && (state_nx == state)) ? cnt + 16'd1 : 16'd0;
  end

endmodule

// File: tb/tb_wb_ibus_dbus_arbiter.sv
// Directed bench for wb_ibus_dbus_arbiter with TIMEOUT=8; inputs change 1ns after posedge.
module tb_wb_ibus_dbus_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] m_adr [2];
  logic [31:0] m_dat [2];
  logic [3:0]  m_sel [2];
  logic        m_we  [2];
  logic        m_cyc [2];
  logic        m_stb [2];
  logic [2:0]  m_cti [2];
  logic [1:0]  m_bte [2];
  logic [31:0] m0_rdt, m1_rdt, s_dat, s_rdt;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] s_adr;
  logic [3:0]  s_sel;
  logic        s_we, s_cyc, s_stb, s_ack, s_err, timeout;
  logic [2:0]  s_cti;
  logic [1:0]  s_bte, grant;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wb_ibus_dbus_arbiter #(.AW(32), .TIMEOUT(8)) dut (
    .clk(clk), .rstn(rstn),
    .i_m0_adr(m_adr[0]), .i_m0_dat(m_dat[0]), .i_m0_sel(m_sel[0]), .i_m0_we(m_we[0]),
    .i_m0_cyc(m_cyc[0]), .i_m0_stb(m_stb[0]), .i_m0_cti(m_cti[0]), .i_m0_bte(m_bte[0]),
    .o_m0_rdt(m0_rdt), .o_m0_ack(m0_ack), .o_m0_err(m0_err),
    .i_m1_adr(m_adr[1]), .i_m1_dat(m_dat[1]), .i_m1_sel(m_sel[1]), .i_m1_we(m_we[1]),
    .i_m1_cyc(m_cyc[1]), .i_m1_stb(m_stb[1]), .i_m1_cti(m_cti[1]), .i_m1_bte(m_bte[1]),
    .o_m1_rdt(m1_rdt), .o_m1_ack(m1_ack), .o_m1_err(m1_err),
    .o_s_adr(s_adr), .o_s_dat(s_dat), .o_s_sel(s_sel), .o_s_we(s_we),
    .o_s_cyc(s_cyc), .o_s_stb(s_stb), .o_s_cti(s_cti), .o_s_bte(s_bte),
    .i_s_rdt(s_rdt), .i_s_ack(s_ack), .i_s_err(s_err),
    .o_timeout(timeout), .o_grant(grant)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int i = 0; i < 2; i++) begin
      m_adr[i] = '0; m_dat[i] = '0; m_sel[i] = '0; m_we[i] = 1'b0;
      m_cyc[i] = 1'b0; m_stb[i] = 1'b0; m_cti[i] = '0; m_bte[i] = '0;
    end
    s_rdt = '0; s_ack = 1'b0; s_err = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    idle_all();
    rstn = 1'b0;
    #2;
    n_tests++; if (grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b want 00", grant); end
    n_tests++; if ({s_cyc, s_stb, s_we} !== 3'b000) begin n_fail++; $display("FAIL reset_s_ctl: got %b want 000", {s_cyc, s_stb, s_we}); end
    n_tests++; if ({m0_ack, m0_err, m1_ack, m1_err, timeout} !== 5'b0) begin n_fail++; $display("FAIL reset_resp: got %b want 00000", {m0_ack, m0_err, m1_ack, m1_err, timeout}); end
    n_tests++; if (s_adr !== 32'h0) begin n_fail++; $display("FAIL reset_s_adr: got %h want 0", s_adr); end
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_single_read();
    idle_all();
    tick();
    m_adr[0] = 32'h0000_0100; m_sel[0] = 4'hf; m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    #1;
    n_tests++; if (s_cyc !== 1'b0) begin n_fail++; $display("FAIL single_no_early_cyc: got %b want 0", s_cyc); end
    tick();
    n_tests++; if (s_cyc !== 1'b1 || s_adr !== 32'h100) begin n_fail++; $display("FAIL single_s_req: got cyc=%b adr=%h want cyc=1 adr=100", s_cyc, s_adr); end
    n_tests++; if (grant !== 2'b01) begin n_fail++; $display("FAIL single_grant: got %b want 01", grant); end
    tick();
    s_ack = 1'b1; s_rdt = 32'hDEAD_BEEF;
    #1;
    n_tests++; if (m0_ack !== 1'b1 || m0_rdt !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_ack: got ack=%b rdt=%h want 1 deadbeef", m0_ack, m0_rdt); end
    n_tests++; if (m1_ack !== 1'b0) begin n_fail++; $display("FAIL single_m1_ack: got %b want 0", m1_ack); end
    tick();
    s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    #1;
    n_tests++; if (s_cyc !== 1'b0 || grant !== 2'b01) begin n_fail++; $display("FAIL single_drop: got cyc=%b grant=%b want 0 01", s_cyc, grant); end
    tick();
    n_tests++; if (grant !== 2'b00) begin n_fail++; $display("FAIL single_idle: got %b want 00", grant); end
  endtask

  task automatic test_tie_alternate();
    int done [2];
    int e;
    idle_all();
    do_reset();
    done[0] = 0; done[1] = 0;
    m_adr[0] = 32'h1000; m_adr[1] = 32'h2000;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      e = i % 2;
      n_tests++; if (grant !== (e ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL tie_grant_%0d: got %b want %b", i, grant, (e ? 2'b10 : 2'b01)); end
      s_ack = 1'b1;
      #1;
      n_tests++; if ({m1_ack, m0_ack} !== (e ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL tie_ack_%0d: got %b want %b", i, {m1_ack, m0_ack}, (e ? 2'b10 : 2'b01)); end
      done[e]++;
      tick();
      s_ack = 1'b0; m_cyc[e] = 1'b0; m_stb[e] = 1'b0;
      tick();
      m_cyc[e] = (done[e] < 4); m_stb[e] = (done[e] < 4);
    end
    n_tests++; if (grant !== 2'b00) begin n_fail++; $display("FAIL tie_end_idle: got %b want 00", grant); end
  endtask

  task automatic test_burst_hold();
    idle_all();
    tick();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_cti[0] = 3'b010; m_adr[0] = 32'h200;
    tick();
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_adr[1] = 32'h900;
    for (int b = 0; b < 4; b++) begin
      m_adr[0] = 32'h200 + 32'(4 * b);
      m_cti[0] = (b == 3) ? 3'b111 : 3'b010;
      s_ack = 1'b1;
      #1;
      n_tests++; if (grant !== 2'b01 || s_adr !== m_adr[0] || s_cti !== m_cti[0]) begin n_fail++; $display("FAIL burst_beat_%0d: got grant=%b adr=%h cti=%b want 01 %h %b", b, grant, s_adr, s_cti, m_adr[0], m_cti[0]); end
      n_tests++; if (m1_ack !== 1'b0 || m0_ack !== 1'b1) begin n_fail++; $display("FAIL burst_ack_%0d: got m0=%b m1=%b want 1 0", b, m0_ack, m1_ack); end
      tick();
    end
    s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0; m_cti[0] = 3'b000;
    #1;
    n_tests++; if (grant !== 2'b01 || s_cyc !== 1'b0) begin n_fail++; $display("FAIL burst_release: got grant=%b cyc=%b want 01 0", grant, s_cyc); end
    tick();
    n_tests++; if (grant !== 2'b10 || s_adr !== 32'h900) begin n_fail++; $display("FAIL burst_handoff: got grant=%b adr=%h want 10 900", grant, s_adr); end
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0; m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    idle_all();
    tick();
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b1; m_adr[1] = 32'h3000; m_dat[1] = 32'h1234_5678;
    tick();
    for (int k = 0; k < 8; k++) begin
      n_tests++; if (s_stb !== 1'b1 || m1_err !== 1'b0 || timeout !== 1'b0) begin n_fail++; $display("FAIL to_stall_%0d: got stb=%b err=%b to=%b want 1 0 0", k, s_stb, m1_err, timeout); end
      tick();
    end
    n_tests++; if (m1_err !== 1'b1 || timeout !== 1'b1 || m0_err !== 1'b0) begin n_fail++; $display("FAIL to_abort: got m1_err=%b to=%b m0_err=%b want 1 1 0", m1_err, timeout, m0_err); end
    n_tests++; if (s_cyc !== 1'b0 || s_stb !== 1'b0) begin n_fail++; $display("FAIL to_abort_bus: got cyc=%b stb=%b want 0 0", s_cyc, s_stb); end
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    tick();
    n_tests++; if (timeout !== 1'b0 || m1_err !== 1'b0 || grant !== 2'b00) begin n_fail++; $display("FAIL to_after: got to=%b err=%b grant=%b want 0 0 00", timeout, m1_err, grant); end
    s_ack = 1'b1;
    #1;
    n_tests++; if (m0_ack !== 1'b0 || m1_ack !== 1'b0) begin n_fail++; $display("FAIL to_spurious_ack: got m0=%b m1=%b want 0 0", m0_ack, m1_ack); end
    s_ack = 1'b0;
  endtask

  task automatic test_ack_at_limit();
    idle_all();
    tick();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 32'h4000;
    tick();
    for (int k = 0; k < 7; k++) tick();
    s_ack = 1'b1; s_rdt = 32'hA5A5_0001;
    #1;
    n_tests++; if (m0_ack !== 1'b1 || m0_err !== 1'b0 || timeout !== 1'b0) begin n_fail++; $display("FAIL lim_ack: got ack=%b err=%b to=%b want 1 0 0", m0_ack, m0_err, timeout); end
    tick();
    s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    #1;
    n_tests++; if (timeout !== 1'b0 || m0_err !== 1'b0 || grant !== 2'b01) begin n_fail++; $display("FAIL lim_no_abort: got to=%b err=%b grant=%b want 0 0 01", timeout, m0_err, grant); end
    tick();
    n_tests++; if (grant !== 2'b00) begin n_fail++; $display("FAIL lim_idle: got %b want 00", grant); end
  endtask

  task automatic test_reset_mid_burst();
    idle_all();
    tick();
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_cti[1] = 3'b010; m_adr[1] = 32'h5000;
    tick();
    n_tests++; if (grant !== 2'b10) begin n_fail++; $display("FAIL rst_pre_grant: got %b want 10", grant); end
    s_ack = 1'b1;
    tick();
    m_adr[1] = 32'h5004;
    #1;
    rstn = 1'b0;
    #1;
    n_tests++; if (grant !== 2'b00 || s_cyc !== 1'b0 || s_adr !== 32'h0) begin n_fail++; $display("FAIL rst_async: got grant=%b cyc=%b adr=%h want 00 0 0", grant, s_cyc, s_adr); end
    n_tests++; if (m1_ack !== 1'b0 || m1_rdt !== 32'h0) begin n_fail++; $display("FAIL rst_async_resp: got ack=%b rdt=%h want 0 0", m1_ack, m1_rdt); end
    idle_all();
    tick();
    rstn = 1'b1;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    tick();
    n_tests++; if (grant !== 2'b01) begin n_fail++; $display("FAIL rst_tie_m0: got %b want 01", grant); end
    idle_all();
    tick();
    tick();
  endtask

  initial begin
    rstn = 1'b0;
    idle_all();
    test_reset();
    test_single_read();
    test_tie_alternate();
    test_burst_hold();
    test_timeout();
    test_ack_at_limit();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_ibus_dbus_arbiter.md
Name: wb_ibus_dbus_arbiter

Overview:
Two-master, one-slave Wishbone B4 arbiter. It lets the core's instruction bus (m0) and data bus (m1) share a single slave port, e.g. the main RAM, without going through the full intercon. Grant is registered and held for a whole cycle (CYC high), including incrementing bursts. Ties are broken round-robin, and a per-transfer watchdog terminates hung slave accesses with ERR.

Parameters:
AW, 32, address width on all ports
TIMEOUT, 1024, cycles with STB high and no ACK/ERR before forced abort; 0 disables the watchdog (max 65535)

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
i_m0_adr  in  AW  ibus address
i_m0_dat  in  32  ibus write data
i_m0_sel  in  4  ibus byte select
i_m0_we  in  1  ibus write enable
i_m0_cyc  in  1  ibus cycle
i_m0_stb  in  1  ibus strobe
i_m0_cti  in  3  ibus cycle type
i_m0_bte  in  2  ibus burst type
o_m0_rdt  out  32  ibus read data
o_m0_ack  out  1  ibus ack
o_m0_err  out  1  ibus error
i_m1_*, o_m1_*  same set as m0  dbus
o_s_adr, o_s_dat, o_s_sel, o_s_we, o_s_cyc, o_s_stb, o_s_cti, o_s_bte  out  AW/32/4/1/1/1/3/2  slave request
i_s_rdt  in  32  slave read data
i_s_ack  in  1  slave ack
i_s_err  in  1  slave error
o_timeout  out  1  one-cycle pulse when the watchdog fires
o_grant  out  2  one-hot current grant ({m1,m0}); 00 when idle

Behaviour:
- Reset (rstn low, async): state=IDLE, last=m1, counter=0. All o_* low; o_s_* fields low.
- States:
  - IDLE: o_s_cyc and o_s_stb low; o_grant=00.
  - G0: slave driven by m0.
  - G1: slave driven by m1.
- Arbitration (evaluated at the clock edge):
  - IDLE, only mX cyc high -> GX.
  - IDLE, both cyc high -> grant the master that is not `last`.
  - After reset, m0 wins the first tie.
  - `last` updates on every grant.
- Latency: the slave sees a request one cycle after the master raises CYC from IDLE.
- In GX:
  - All o_s_* fields equal mX's inputs combinationally.
  - i_s_rdt goes to both o_mX_rdt outputs.
  - i_s_ack/i_s_err route only to mX; the non-granted master's ack/err are held 0.
- Grant hold: GX persists while i_mX_cyc is high, regardless of STB gaps or CTI (classic, 010 incrementing, 111 end-of-burst).
- Release: at the edge where i_mX_cyc is low in GX:
  - if the other master's cyc is high -> go directly to its grant state (no IDLE bubble); `last` updates;
  - else -> IDLE.
  - o_s_cyc follows i_mX_cyc combinationally, so the slave sees CYC drop in that same cycle.
- Watchdog (TIMEOUT>0):
  - 16-bit counter increments each cycle in GX with o_s_stb high and neither i_s_ack nor i_s_err.
  - Cleared on ack, err, STB low, or leaving GX.
  - When counter==TIMEOUT-1 and still no ack/err, the next cycle is ABORT:
    - o_mX_err=1 for one cycle; o_timeout=1;
    - o_s_cyc and o_s_stb forced 0;
    - then IDLE, with `last`=X.
  - Late i_s_ack/i_s_err arriving in ABORT or IDLE is discarded, never forwarded.
- Simultaneous events:
  - Slave ack in the same cycle the counter would fire: ack wins, no abort.
  - Master drops CYC during ABORT: no effect; ABORT always lasts exactly one cycle.
- Reset mid-transfer: outputs clear asynchronously and the transfer is lost; masters must restart it.
- No combinational path from i_s_* to o_s_*. The grant mux is driven by registered state only.

Test Plan:
- m0 single read, m1 idle, slave acks on its 2nd STB cycle with rdt=0xDEADBEEF -> o_s_cyc rises 1 cycle after i_m0_cyc; o_m0_ack=1 with o_m0_rdt=0xDEADBEEF; o_m1_ack stays 0; o_grant=01 then 00.
- m0 and m1 raise CYC in the same cycle right after reset, each issuing 4 sequential single transfers -> grants alternate m0,m1,m0,m1 with no IDLE cycle between handoffs.
- m0 4-beat burst (cti 010,010,010,111) while m1 requests from beat 1 -> m1 is not granted until m0 drops CYC after the 111 beat; then o_grant=10 on the next edge.
- TIMEOUT=8, m1 write, slave never acks -> exactly 8 cycles of stalled STB, then one cycle with o_m1_err=1, o_timeout=1, o_s_cyc=0; state IDLE. A later spurious i_s_ack is not forwarded to either master.
- TIMEOUT=8, slave acks in the 8th stalled cycle -> normal ack, no err, no o_timeout.
- rstn pulsed low mid-burst in G1 -> all outputs 0 immediately (asynchronously); after release, a tie grants m0 first.
